gcd_bcd_display: RTL and testbench

Downstream result stage for the Greatest Common Divisor unit. On each `done` pulse it captures the 16-bit `gcd` result and converts it to packed BCD with a sequential shift-add-3 (double-dabble) engine. It then drives a 4-digit, active-low, multiplexed seven-segment display. The block also exposes the BCD value and a valid flag so other blocks can read the result.

---
 rtl/gcd_bcd_display.sv | 163 ++++++++++++++++
 tb/tb_gcd_bcd_display.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_bcd_display.sv
// Result stage for the GCD unit: converts the captured result to BCD with a sequential
// double-dabble engine and scans it onto a 4-digit seven-segment display. GCD_LEADING_ZERO_BLANK_EN enables leading-zero blanking.
module gcd_bcd_display #(
    parameter int REFRESH_BITS = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        done,
    input  logic [15:0] gcd,
    output logic        busy,
    output logic        valid,
    output logic [19:0] bcd,
    output logic [3:0]  an,
    output logic [6:0]  seg
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] CONV = 1'b1;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    logic [0:0]              state_reg;
    logic [15:0]             sreg_reg;
    logic [19:0]             acc_reg;
    logic [3:0]              iter_reg;
    logic [19:0]             bcd_reg;
    logic                    valid_reg;
    logic [REFRESH_BITS-1:0] cnt_reg;
    logic [3:0]              an_reg;
    logic [6:0]              seg_reg;

    logic [19:0]             acc_adj;
    logic [19:0]             acc_next;
    logic [15:0]             sreg_next;
    logic [1:0]              digit_sel;
    logic [6:0]              digit_glyph [4];
    logic [3:0]              upper_zero;
    logic [3:0]              an_next;
    logic [6:0]              seg_next;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'b1000000;
            4'd1:    g = 7'b1111001;
            4'd2:    g = 7'b0100100;
            4'd3:    g = 7'b0110000;
            4'd4:    g = 7'b0011001;
            4'd5:    g = 7'b0010010;
            4'd6:    g = 7'b0000010;
            4'd7:    g = 7'b1111000;
            4'd8:    g = 7'b0000000;
            4'd9:    g = 7'b0010000;
            default: g = SEG_BLANK;
        endcase
        return g;
    endfunction

    // Add-3 correction on every nibble that would overflow past 9 after the shift.
    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_adjust
            assign acc_adj[4*gi +: 4] = (acc_reg[4*gi +: 4] >= 4'd5) ?
                                        acc_reg[4*gi +: 4] + 4'd3 :
                                        acc_reg[4*gi +: 4];
        end
    endgenerate

    assign acc_next  = {acc_adj[18:0], sreg_reg[15]};
    assign sreg_next = {sreg_reg[14:0], 1'b0};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            sreg_reg  <= 16'd0;
            acc_reg   <= 20'd0;
            iter_reg  <= 4'd0;
            bcd_reg   <= 20'd0;
            valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (done) begin
                        sreg_reg  <= gcd;
                        acc_reg   <= 20'd0;
                        iter_reg  <= 4'd0;
                        state_reg <= CONV;
                    end
                end
                CONV: begin
                    acc_reg  <= acc_next;
                    sreg_reg <= sreg_next;
                    iter_reg <= iter_reg + 4'd1;
                    if (iter_reg == 4'd15) begin
                        bcd_reg   <= acc_next;
                        valid_reg <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign digit_sel = cnt_reg[REFRESH_BITS-1 -: 2];

    // upper_zero[k]: digit k and everything above it (within the four shown digits) is zero.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            assign digit_glyph[gi] = glyph(bcd_reg[4*gi +: 4]);
            assign upper_zero[gi]  = (bcd_reg[15:4*gi] == '0);
        end
    endgenerate

    always_comb begin
        an_next  = 4'b1111;
        seg_next = SEG_BLANK;
        if (valid_reg) begin
            an_next = ~(4'b0001 << digit_sel);
            if (bcd_reg[19:16] != 4'd0) begin
                seg_next = SEG_DASH;
            end else begin
                seg_next = digit_glyph[digit_sel];
`ifdef GCD_LEADING_ZERO_BLANK_EN
                if (digit_sel != 2'd0 && upper_zero[digit_sel]) begin
                    an_next  = 4'b1111;
                    seg_next = SEG_BLANK;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an_reg  <= 4'b1111;
            seg_reg <= SEG_BLANK;
        end else begin
            an_reg  <= an_next;
            seg_reg <= seg_next;
        end
    end

`ifndef GCD_LEADING_ZERO_BLANK_EN
    logic unused_upper_zero;
    assign unused_upper_zero = ^upper_zero;
`endif

    assign busy  = (state_reg == CONV);
    assign valid = valid_reg;
    assign bcd   = bcd_reg;
    assign an    = an_reg;
    assign seg   = seg_reg;

endmodule

// File: tb/tb_gcd_bcd_display.sv
// Scoreboard bench for gcd_bcd_display: stimulus pushes expected BCD results, a monitor
// pops and compares on each conversion completion; display scans are checked directly.
module tb_gcd_bcd_display;

    localparam int RB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        done;
    logic [15:0] gcd;
    logic        busy;
    logic        valid;
    logic [19:0] bcd;
    logic [3:0]  an;
    logic [6:0]  seg;

    int compared   = 0;
    int mismatched = 0;

    logic [19:0] exp_q [$];
    logic        busy_d   = 1'b0;
    logic        rst_seen = 1'b0;

    gcd_bcd_display #(.REFRESH_BITS(RB)) dut (
        .clk   (clk),
        .rst   (rst),
        .done  (done),
        .gcd   (gcd),
        .busy  (busy),
        .valid (valid),
        .bcd   (bcd),
        .an    (an),
        .seg   (seg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] ref_glyph(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    always @(posedge clk) rst_seen = rst;

    // Monitor: a busy falling edge not caused by reset is a completed conversion.
    always @(negedge clk) begin
        if (busy_d && !busy && !rst_seen) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_completion: got bcd %0h expected no completion", bcd);
            end else begin
                logic [19:0] e;
                e = exp_q.pop_front();
                chk("result_bcd", {12'd0, bcd}, {12'd0, e});
                chk("result_valid", {31'd0, valid}, 32'd1);
                $display("completion: bcd=%05h expected=%05h", bcd, e);
            end
        end
        busy_d = busy;
    end

    task automatic issue(input logic [15:0] v, input logic [19:0] e, input bit push);
        @(posedge clk);
        #1;
        done = 1'b1;
        gcd  = v;
        if (push) exp_q.push_back(e);
        @(posedge clk);
        #1;
        done = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) begin
            compared++;
            mismatched++;
            $display("FAIL wait_idle: busy still %0b after %0d cycles, required 0", busy, n);
        end
    endtask

    task automatic check_display(input logic [19:0] v, input string tag);
        logic [6:0] eg [4];
        logic [3:0] mask;
        logic [3:0] seen;
        int         k;
        bit         dash;
        dash = (v[19:16] != 4'd0);
        for (int i = 0; i < 4; i++) begin
            eg[i] = dash ? 7'b0111111 : ref_glyph(v[4*i +: 4]);
        end
        mask = 4'b1111;
`ifdef GCD_LEADING_ZERO_BLANK_EN
        if (!dash) begin
            mask[0] = 1'b1;
            for (int i = 1; i < 4; i++) mask[i] = ((v[15:0] >> (4*i)) != 16'd0);
        end
`endif
        seen = 4'b0000;
        repeat (2) @(negedge clk);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (an != 4'b1111) begin
                if ($countones(~an) != 1) begin
                    chk({tag, "_an_onehot"}, {28'd0, an}, 32'd0);
                end else begin
                    k = (!an[0]) ? 0 : (!an[1]) ? 1 : (!an[2]) ? 2 : 3;
                    seen[k] = 1'b1;
                    chk({tag, "_seg"}, {25'd0, seg}, {25'd0, eg[k]});
                end
            end
        end
        chk({tag, "_digits_shown"}, {28'd0, seen}, {28'd0, mask});
        $display("display %s: value=%05h digits_shown=%04b expected=%04b", tag, v, seen, mask);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst  = 1'b1;
        done = 1'b0;
        gcd  = 16'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_an", {28'd0, an}, 32'hF);
        chk("reset_seg", {25'd0, seg}, 32'h7F);
        chk("reset_valid", {31'd0, valid}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_bcd", {12'd0, bcd}, 32'd0);
        $display("reset: an=%04b seg=%07b valid=%0b busy=%0b bcd=%05h", an, seg, valid, busy, bcd);

        // gcd=6: busy exactly 16 cycles
        issue(16'd6, 20'h00006, 1'b1);
        n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("busy_cycles", n, 32'd16);
        $display("gcd=6: busy for %0d cycles", n);
        check_display(20'h00006, "six");

        issue(16'd12345, 20'h12345, 1'b1);
        wait_idle();
        check_display(20'h12345, "dash12345");

        // A new capture keeps the previous result visible
        issue(16'd1234, 20'h01234, 1'b1);
        @(negedge clk);
        chk("hold_valid", {31'd0, valid}, 32'd1);
        chk("hold_bcd", {12'd0, bcd}, 32'h12345);
        wait_idle();
        check_display(20'h01234, "v1234");

        // Second done during conversion must be ignored
        issue(16'd9999, 20'h09999, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        done = 1'b1;
        gcd  = 16'd4;
        @(posedge clk);
        #1 done = 1'b0;
        wait_idle();
        repeat (30) @(negedge clk);
        chk("ignored_done_bcd", {12'd0, bcd}, 32'h09999);

        // Reset on cycle 8 of the conversion aborts it
        issue(16'd3, 20'h00003, 1'b0);
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_valid", {31'd0, valid}, 32'd0);
        chk("abort_bcd", {12'd0, bcd}, 32'd0);
        repeat (30) @(negedge clk);
        chk("abort_valid_later", {31'd0, valid}, 32'd0);
        chk("abort_bcd_later", {12'd0, bcd}, 32'd0);
        chk("abort_an", {28'd0, an}, 32'hF);
        $display("abort: busy=%0b valid=%0b bcd=%05h", busy, valid, bcd);

        issue(16'd0, 20'h00000, 1'b1);
        wait_idle();
        check_display(20'h00000, "zero");

        issue(16'd100, 20'h00100, 1'b1);
        wait_idle();
        check_display(20'h00100, "v100");

        issue(16'd65535, 20'h65535, 1'b1);
        wait_idle();
        check_display(20'h65535, "dash65535");

        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
